// File: rtl/acc_out_pkg.sv
// acc_out_pkg: opcodes and signed saturation-limit helpers shared by the accumulator/output slice.
// Revision 1.0
`default_nettype none

package acc_out_pkg;

  localparam logic [2:0] OP_NOP       = 3'b000;
  localparam logic [2:0] OP_ACC       = 3'b001;
  localparam logic [2:0] OP_FLUSH     = 3'b010;
  localparam logic [2:0] OP_CAT_START = 3'b011;
  localparam logic [2:0] OP_CAT_END   = 3'b100;
  localparam logic [2:0] OP_CLR       = 3'b101;
  localparam logic [2:0] OP_CLR_ALL   = 3'b110;

  // Limits are returned at a fixed wide width so any operand can be sign-extended and compared.
  localparam int LIM_W = 128;

  function automatic logic signed [LIM_W-1:0] smax(input int w);
    return (LIM_W'(1) << (w - 1)) - LIM_W'(1);
  endfunction

  function automatic logic signed [LIM_W-1:0] smin(input int w);
    return ~smax(w);
  endfunction

endpackage

`default_nettype wire

// File: rtl/acc_sat_add.sv
// acc_sat_add: combinational signed accumulate with ACC_W saturation and overflow flag.
// Revision 1.0
`default_nettype none

module acc_sat_add #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 40
) (
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [DATA_W-1:0] i_data,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_ovf
);

  logic signed [ACC_W:0] w_sum;

  // One guard bit makes overflow visible as a disagreement of the top two bits.
  assign w_sum = $signed({i_acc[ACC_W-1], i_acc})
               + $signed({{(ACC_W + 1 - DATA_W){i_data[DATA_W-1]}}, i_data});

  assign o_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];

  always_comb begin
    o_sum = w_sum[ACC_W-1:0];
    if (o_ovf) begin
      o_sum = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

endmodule

`default_nettype wire

// File: rtl/acc_out_multi.sv
// acc_out_multi: per-channel saturating accumulators with opcoded commands and a framed, clamped output stage.
// Revision 1.0
`default_nettype none

module acc_out_multi
  import acc_out_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 40,
  parameter int CH     = 4,
  localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_last,
  output logic              out_sat,
  output logic              cat_active
);

  logic [ACC_W-1:0]  r_acc [CH];
  logic [CH-1:0]     r_sat;
  logic              r_cat;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [CH_W-1:0]   r_out_ch;
  logic              r_out_last;
  logic              r_out_sat;

  logic              w_fire;
  logic              w_ch_ok;
  logic [ACC_W-1:0]  w_sel_acc;
  logic              w_sel_sat;
  logic [ACC_W-1:0]  w_sum;
  logic              w_ovf;
  logic signed [LIM_W-1:0] w_acc_wide;
  logic              w_hi;
  logic              w_lo;
  logic [DATA_W-1:0] w_clamped;

  assign in_ready  = !r_out_valid || out_ready;
  assign w_fire    = in_valid && in_ready;
  assign w_ch_ok   = (32'(in_ch) < CH);
  assign w_sel_acc = r_acc[in_ch];
  assign w_sel_sat = r_sat[in_ch];

  acc_sat_add #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .i_acc  (w_sel_acc),
    .i_data (in_data),
    .o_sum  (w_sum),
    .o_ovf  (w_ovf)
  );

  assign w_acc_wide = $signed({{(LIM_W - ACC_W){w_sel_acc[ACC_W-1]}}, w_sel_acc});
  assign w_hi       = w_acc_wide > smax(DATA_W);
  assign w_lo       = w_acc_wide < smin(DATA_W);

  always_comb begin
    w_clamped = w_sel_acc[DATA_W-1:0];
    if (w_hi) w_clamped = {1'b0, {(DATA_W-1){1'b1}}};
    if (w_lo) w_clamped = {1'b1, {(DATA_W-1){1'b0}}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CH; i++) r_acc[i] <= '0;
      r_sat       <= '0;
      r_cat       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_last  <= 1'b0;
      r_out_sat   <= 1'b0;
    end else begin
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      // A command addressed past the last channel is swallowed whole.
      if (w_fire && w_ch_ok) begin
        case (in_op)
          OP_ACC: begin
            r_acc[in_ch] <= w_sum;
            r_sat[in_ch] <= w_sel_sat | w_ovf;
          end
          OP_FLUSH, OP_CAT_END: begin
            r_out_valid  <= 1'b1;
            r_out_data   <= w_clamped;
            r_out_ch     <= in_ch;
            r_out_last   <= (in_op == OP_CAT_END) || !r_cat;
            r_out_sat    <= w_sel_sat | w_hi | w_lo;
            r_acc[in_ch] <= '0;
            r_sat[in_ch] <= 1'b0;
            if (in_op == OP_CAT_END) r_cat <= 1'b0;
          end
          OP_CAT_START: r_cat <= 1'b1;
          OP_CLR: begin
            r_acc[in_ch] <= '0;
            r_sat[in_ch] <= 1'b0;
          end
          OP_CLR_ALL: begin
            for (int i = 0; i < CH; i++) r_acc[i] <= '0;
            r_sat <= '0;
            r_cat <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_ch     = r_out_ch;
  assign out_last   = r_out_last;
  assign out_sat    = r_out_sat;
  assign cat_active = r_cat;

endmodule

`default_nettype wire

// File: tb/tb_acc_out_multi.sv
// tb_acc_out_multi: directed scenarios plus random commands against an arithmetic reference model.
// Revision 1.0
`default_nettype none

module tb_acc_out_multi;

  localparam logic [2:0] NOP = 3'd0, ACC = 3'd1, FLUSH = 3'd2, CSTART = 3'd3,
                         CEND = 3'd4, CLR = 3'd5, CLRALL = 3'd6, RSV = 3'd7;
  localparam longint AMAX = (64'sd1 <<< 39) - 64'sd1;
  localparam longint AMIN = -(64'sd1 <<< 39);
  localparam longint DMAX = 64'sd2147483647;
  localparam longint DMIN = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = 3'd0;
  logic [1:0]  in_ch = 2'd0;
  logic [31:0] in_data = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [1:0]  out_ch;
  logic        out_last;
  logic        out_sat;
  logic        cat_active;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state
  longint m_acc [4];
  bit     m_sat [4];
  bit     m_cat;
  bit     e_valid;
  longint e_data;
  int     e_ch;
  bit     e_last;
  bit     e_sat;

  always #5 clk = ~clk;

  acc_out_multi #(.DATA_W(32), .ACC_W(40), .CH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_ch      (in_ch),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ch     (out_ch),
    .out_last   (out_last),
    .out_sat    (out_sat),
    .cat_active (cat_active)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_acc[i] = 0;
      m_sat[i] = 0;
    end
    m_cat   = 0;
    e_valid = 0;
    e_data  = 0;
    e_ch    = 0;
    e_last  = 0;
    e_sat   = 0;
  endtask

  task automatic model_cmd(input bit fire, input logic [2:0] op, input int ch,
                           input logic [31:0] d, input bit ordy);
    longint s;
    if (e_valid && ordy) e_valid = 0;
    if (!fire) return;
    case (op)
      ACC: begin
        s = m_acc[ch] + longint'($signed(d));
        if (s > AMAX) begin s = AMAX; m_sat[ch] = 1; end
        if (s < AMIN) begin s = AMIN; m_sat[ch] = 1; end
        m_acc[ch] = s;
      end
      FLUSH, CEND: begin
        s = m_acc[ch];
        if (s > DMAX) s = DMAX;
        if (s < DMIN) s = DMIN;
        e_valid   = 1;
        e_data    = s;
        e_ch      = ch;
        e_last    = (op == CEND) || !m_cat;
        e_sat     = m_sat[ch] || (s != m_acc[ch]);
        m_acc[ch] = 0;
        m_sat[ch] = 0;
        if (op == CEND) m_cat = 0;
      end
      CSTART: m_cat = 1;
      CLR: begin m_acc[ch] = 0; m_sat[ch] = 0; end
      CLRALL: begin
        for (int i = 0; i < 4; i++) begin m_acc[i] = 0; m_sat[i] = 0; end
        m_cat = 0;
      end
      default: ;
    endcase
  endtask

  task automatic check_outs();
    logic [31:0] ed;
    logic [1:0]  ec;
    ed = e_data[31:0];
    ec = e_ch[1:0];
    chk("out_valid", out_valid, e_valid);
    chk("cat_active", cat_active, m_cat);
    if (e_valid) begin
      chk("out_data", out_data, ed);
      chk("out_ch", out_ch, ec);
      chk("out_last", out_last, e_last);
      chk("out_sat", out_sat, e_sat);
    end
  endtask

  // One clock of stimulus; the outcome of the previous cycle is checked first.
  task automatic step(input bit v, input logic [2:0] op, input int ch,
                      input logic [31:0] d, input bit ordy);
    bit exp_rdy;
    @(negedge clk);
    check_outs();
    in_valid  = v;
    in_op     = op;
    in_ch     = ch[1:0];
    in_data   = d;
    out_ready = ordy;
    #1;
    exp_rdy = !e_valid || ordy;
    chk("in_ready", in_ready, exp_rdy);
    model_cmd(v && exp_rdy, op, ch, d, ordy);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_ch"}, out_ch, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_out_sat"}, out_sat, 0);
    chk({tag, "_cat_active"}, cat_active, 0);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] d;
    int          r;

    model_reset();
    #12;
    check_reset_values("rst");
    @(negedge clk);
    rst = 1'b1;

    // Basic accumulate and flush on ch1
    step(1, ACC, 1, 32'd5, 1);
    step(1, ACC, 1, -32'sd3, 1);
    step(1, FLUSH, 1, 0, 1);
    step(0, NOP, 0, 0, 0);
    chk("t1_data", out_data, 2);
    chk("t1_ch", out_ch, 1);
    chk("t1_last", out_last, 1);
    chk("t1_sat", out_sat, 0);
    step(1, FLUSH, 1, 0, 1);
    step(0, NOP, 0, 0, 0);
    chk("t1_zero", out_data, 0);

    // Output clamp without accumulator overflow
    for (int i = 0; i < 3; i++) step(1, ACC, 0, 32'h7FFF_FFFF, 1);
    step(1, FLUSH, 0, 0, 1);
    step(0, NOP, 0, 0, 0);
    chk("t2_data", out_data, 32'h7FFF_FFFF);
    chk("t2_sat", out_sat, 1);

    // Accumulator saturation
    for (int i = 0; i < 300; i++) step(1, ACC, 2, 32'h7FFF_FFFF, 1);
    step(1, FLUSH, 2, 0, 1);
    step(0, NOP, 0, 0, 0);
    chk("t3_data", out_data, 32'h7FFF_FFFF);
    chk("t3_sat", out_sat, 1);
    step(1, FLUSH, 2, 0, 1);
    step(0, NOP, 0, 0, 0);
    chk("t3_sat_cleared", out_sat, 0);

    // Concatenated frame
    step(1, CSTART, 0, 0, 1);
    step(1, FLUSH, 0, 0, 1);
    step(1, FLUSH, 1, 0, 1);
    step(1, CEND, 2, 0, 1);
    step(0, NOP, 0, 0, 0);
    chk("t4_last", out_last, 1);
    chk("t4_ch", out_ch, 2);
    chk("t4_cat", cat_active, 0);

    // Backpressure holds output and stalls commands
    step(0, NOP, 0, 0, 1);
    step(1, ACC, 3, 32'd7, 1);
    step(1, FLUSH, 3, 0, 0);
    step(1, ACC, 3, 32'd100, 0);
    chk("t5_stall", in_ready, 0);
    step(1, ACC, 3, 32'd100, 0);
    chk("t5_hold_data", out_data, 7);
    step(1, ACC, 3, 32'd100, 1);
    chk("t5_accept", in_ready, 1);
    step(1, FLUSH, 3, 0, 1);
    step(0, NOP, 0, 0, 0);
    chk("t5_data", out_data, 100);

    // Asynchronous reset with a frame open and a stalled result
    step(0, NOP, 0, 0, 1);
    step(1, CSTART, 0, 0, 1);
    step(1, ACC, 0, 32'd9, 1);
    step(1, FLUSH, 0, 0, 0);
    step(0, NOP, 0, 0, 0);
    rst = 1'b0;
    model_reset();
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    rst = 1'b1;
    step(1, FLUSH, 0, 0, 1);
    step(0, NOP, 0, 0, 0);
    chk("t6_data", out_data, 0);
    chk("t6_last", out_last, 1);

    // Random commands
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(99);
      if      (r < 45) op = ACC;
      else if (r < 65) op = FLUSH;
      else if (r < 72) op = CSTART;
      else if (r < 79) op = CEND;
      else if (r < 86) op = CLR;
      else if (r < 88) op = CLRALL;
      else if (r < 94) op = NOP;
      else             op = RSV;
      case ($urandom_range(3))
        0:       d = $urandom;
        1:       d = 32'($urandom_range(200)) - 32'd100;
        2:       d = 32'h7FFF_FFFF;
        default: d = 32'h8000_0000;
      endcase
      step($urandom_range(9) < 8, op, int'($urandom_range(3)), d, $urandom_range(9) < 7);
    end
    step(0, NOP, 0, 0, 1);
    step(0, NOP, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
